// File: rtl/cpu_bus_decoder.sv
// cpu_bus_decoder: CPU-side address decoder for the 6502 bus.
// Routes CPU accesses to mirrored work RAM, PPU registers and PRG ROM, and
// owns the serial controller ports at $4016/$4017.
// Optional feature macro: CPU_BUS_OAM_DMA_EN builds the stalling OAM DMA
// engine triggered by a write to $4014. Without it, $4014 writes are ignored
// and all DMA/OAM outputs are tied low.
module cpu_bus_decoder #(
  parameter int NUM_PADS = 2,
  parameter int RAM_AW   = 11,
  parameter int PRG_AW   = 15,
  parameter int DMA_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic                  ram_we,
  input  logic [7:0]            ram_rdata,
  output logic [PRG_AW-1:0]     prg_addr,
  input  logic [7:0]            prg_rdata,
  output logic                  ppu_cs,
  output logic [2:0]            ppu_addr,
  output logic                  ppu_we,
  input  logic [7:0]            ppu_rdata,
  output logic                  cpu_stall,
  output logic                  oam_we,
  output logic [7:0]            oam_addr,
  output logic [7:0]            oam_wdata,
  input  logic [8*NUM_PADS-1:0] pad_state
);

  // High while the DMA engine owns the bus; CPU strobes are dropped then.
  logic dma_busy;
  logic cpu_we;
  logic cpu_re;

  assign cpu_we = we & ~dma_busy;
  assign cpu_re = re & ~dma_busy;

  // Region decode on the live CPU address.
  logic sel_ram;
  logic sel_ppu;
  logic sel_prg;

  assign sel_ram = (addr[15:13] == 3'b000);
  assign sel_ppu = (addr[15:13] == 3'b001);
  assign sel_prg = addr[15];

  assign ram_we   = cpu_we & sel_ram;
  assign ppu_cs   = ~dma_busy & sel_ppu;
  assign ppu_we   = cpu_we & sel_ppu;
  assign ppu_addr = addr[2:0];

  // ---------------------------------------------------------------------
  // Controller ports
  // ---------------------------------------------------------------------
  logic                strobe_q;
  logic [NUM_PADS-1:0] pad_sel;
  logic [NUM_PADS-1:0] pad_bit;

  // The strobe latch is shared by every pad and only written through $4016.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
    end else if (cpu_we && (addr == 16'h4016)) begin
      strobe_q <= data_in[0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic [7:0] sr_q;

      assign pad_sel[gi] = (addr == 16'(16'h4016 + gi));

      // Load continuously while strobed (load beats a read); otherwise shift
      // in ones on each read addressed to this pad only.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sr_q <= 8'hFF;
        end else if (strobe_q) begin
          sr_q <= pad_state[8*gi +: 8];
        end else if (cpu_re && pad_sel[gi]) begin
          sr_q <= {sr_q[6:0], 1'b1};
        end
      end

      // While strobed the A button is seen live rather than through sr.
      assign pad_bit[gi] = strobe_q ? pad_state[8*gi + 7] : sr_q[7];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // OAM DMA engine (optional)
  // ---------------------------------------------------------------------
`ifdef CPU_BUS_OAM_DMA_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] src_data;

  // DMA state, source page and byte index; reset aborts a transfer at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: one alignment cycle, then READ/WRITE pairs per byte.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (we && (addr == 16'h4014)) begin
          state_d = ALIGN;
          page_d  = data_in;
          idx_d   = 8'h00;
        end
      end
      ALIGN: state_d = READ;
      READ:  state_d = WRITE;
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Source byte selected by the page's region; pages outside RAM/PRG read 0.
  always_comb begin
    src_data = 8'h00;
    if (page_q[7:5] == 3'b000) begin
      src_data = ram_rdata;
    end else if (page_q[7]) begin
      src_data = prg_rdata;
    end
  end

  assign dma_busy  = (state_q != IDLE);
  assign cpu_stall = dma_busy;
  assign oam_we    = (state_q == WRITE);
  assign oam_addr  = idx_q;
  assign oam_wdata = (state_q == WRITE) ? src_data : 8'h00;
  assign ram_addr  = dma_busy ? RAM_AW'({page_q, idx_q}) : addr[RAM_AW-1:0];
  assign prg_addr  = dma_busy ? PRG_AW'({page_q, idx_q}) : addr[PRG_AW-1:0];
`else
  logic unused_data_hi;

  assign unused_data_hi = ^data_in[7:1];
  assign dma_busy  = 1'b0;
  assign cpu_stall = 1'b0;
  assign oam_we    = 1'b0;
  assign oam_addr  = 8'h00;
  assign oam_wdata = 8'h00;
  assign ram_addr  = addr[RAM_AW-1:0];
  assign prg_addr  = addr[PRG_AW-1:0];
`endif

  // CPU read mux; the RAM/PRG data arrives one cycle after the address.
  always_comb begin
    data_out = 8'h00;
    if (!dma_busy) begin
      if (sel_ram) begin
        data_out = ram_rdata;
      end else if (sel_ppu) begin
        data_out = ppu_rdata;
      end else if (sel_prg) begin
        data_out = prg_rdata;
      end else begin
        for (int i = 0; i < NUM_PADS; i++) begin
          if (pad_sel[i]) begin
            data_out = {7'b0, pad_bit[i]};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Directed testbench for cpu_bus_decoder (default parameters, two pads).
// DMA scenarios are exercised when CPU_BUS_OAM_DMA_EN is defined; otherwise
// the bench checks that $4014 writes have no effect.
module tb_cpu_bus_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic        we;
  logic        re;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_rdata;
  logic [14:0] prg_addr;
  logic [7:0]  prg_rdata;
  logic        ppu_cs;
  logic [2:0]  ppu_addr;
  logic        ppu_we;
  logic [7:0]  ppu_rdata;
  logic        cpu_stall;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic [15:0] pad_state;

  int tests = 0;
  int fails = 0;

  logic [7:0] ram_mem [0:2047];
  logic [7:0] oam_mem [0:255];

  always #5 clk = ~clk;

  cpu_bus_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .we        (we),
    .re        (re),
    .data_in   (data_in),
    .data_out  (data_out),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .prg_addr  (prg_addr),
    .prg_rdata (prg_rdata),
    .ppu_cs    (ppu_cs),
    .ppu_addr  (ppu_addr),
    .ppu_we    (ppu_we),
    .ppu_rdata (ppu_rdata),
    .cpu_stall (cpu_stall),
    .oam_we    (oam_we),
    .oam_addr  (oam_addr),
    .oam_wdata (oam_wdata),
    .pad_state (pad_state)
  );

  // PRG ROM content: byte at offset a is (a*7+3) mod 256.
  function automatic logic [7:0] prg_model(input logic [14:0] a);
    return 8'(a * 7 + 3);
  endfunction

  // Synchronous RAM and ROM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= data_in;
    ram_rdata <= ram_mem[ram_addr];
    prg_rdata <= prg_model(prg_addr);
  end

  assign ppu_rdata = {5'b11000, ppu_addr};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bus helpers (all start/end at posedge+1) -------------
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; data_in = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic mem_read(input logic [15:0] a, output logic [7:0] d);
    addr = a; re = 1'b1;
    @(posedge clk); #1;
    re = 1'b0;
    #1;
    d = data_out;
  endtask

  task automatic pad_read(input logic [15:0] a, output logic [7:0] d);
    addr = a; re = 1'b1;
    #2;
    d = data_out;
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  // Runs a DMA already triggered, holding a stray write strobe on stray_a.
  task automatic run_dma(input logic [15:0] stray_a, output int n,
                         output int pulses, output int first,
                         output int order_err, output int ram_we_seen);
    n = 0; pulses = 0; first = -1; order_err = 0; ram_we_seen = 0;
    addr = stray_a; data_in = 8'h80; we = 1'b1;
    while (cpu_stall && n < 2000) begin
      if (ram_we) ram_we_seen++;
      if (oam_we) begin
        if (first < 0) first = n;
        if (oam_addr !== 8'(pulses)) order_err++;
        oam_mem[oam_addr] = oam_wdata;
        pulses++;
      end
      n++;
      @(posedge clk); #1;
    end
    we = 1'b0;
  endtask

  // ---------------- tests ------------------------------------------------
  task automatic test_reset();
    logic [7:0] d;
    reset = 1'b1; addr = 16'h0000; we = 1'b0; re = 1'b0;
    data_in = 8'h00; pad_state = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL reset_cpu_stall got %b want 0", cpu_stall); end
    tests++; if (oam_we !== 1'b0) begin fails++; $display("FAIL reset_oam_we got %b want 0", oam_we); end
    tests++; if (oam_addr !== 8'h00) begin fails++; $display("FAIL reset_oam_addr got %h want 00", oam_addr); end
    tests++; if (oam_wdata !== 8'h00) begin fails++; $display("FAIL reset_oam_wdata got %h want 00", oam_wdata); end
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
    tests++; if (ppu_we !== 1'b0) begin fails++; $display("FAIL reset_ppu_we got %b want 0", ppu_we); end
    reset = 1'b0;
    @(posedge clk); #1;
    pad_read(16'h4016, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL reset_pad0_sr got %h want 01", d); end
    pad_read(16'h4017, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL reset_pad1_sr got %h want 01", d); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_ram_mirror();
    logic [7:0] d;
    addr = 16'h0000; data_in = 8'h5A; we = 1'b1;
    #1;
    tests++; if (ram_we !== 1'b1) begin fails++; $display("FAIL ram_we_on_write got %b want 1", ram_we); end
    tests++; if (ram_addr !== 11'h000) begin fails++; $display("FAIL ram_addr_0000 got %h want 000", ram_addr); end
    @(posedge clk); #1;
    we = 1'b0;
    mem_read(16'h0800, d);
    tests++; if (ram_addr !== 11'h000) begin fails++; $display("FAIL ram_addr_0800 got %h want 000", ram_addr); end
    tests++; if (d !== 8'h5A) begin fails++; $display("FAIL ram_mirror_0800 got %h want 5a", d); end
    cpu_write(16'h1FFF, 8'h33);
    mem_read(16'h07FF, d);
    tests++; if (d !== 8'h33) begin fails++; $display("FAIL ram_mirror_1fff got %h want 33", d); end
    $display("[TB] test_ram_mirror done");
  endtask

  task automatic test_ppu();
    logic [7:0] d;
    addr = 16'h3FFA; data_in = 8'h11; we = 1'b1;
    #1;
    tests++; if (ppu_cs !== 1'b1) begin fails++; $display("FAIL ppu_cs got %b want 1", ppu_cs); end
    tests++; if (ppu_we !== 1'b1) begin fails++; $display("FAIL ppu_we got %b want 1", ppu_we); end
    tests++; if (ppu_addr !== 3'd2) begin fails++; $display("FAIL ppu_addr got %0d want 2", ppu_addr); end
    tests++; if (ram_we !== 1'b0) begin fails++; $display("FAIL ppu_ram_we got %b want 0", ram_we); end
    @(posedge clk); #1;
    we = 1'b0;
    mem_read(16'h3FFA, d);
    tests++; if (d !== 8'hC2) begin fails++; $display("FAIL ppu_read got %h want c2", d); end
    addr = 16'h4000; #1;
    tests++; if (ppu_cs !== 1'b0) begin fails++; $display("FAIL ppu_cs_4000 got %b want 0", ppu_cs); end
    $display("[TB] test_ppu done");
  endtask

  task automatic test_unmapped_prg();
    logic [7:0] d;
    cpu_write(16'h5000, 8'hAA);
    mem_read(16'h5000, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL unmapped_5000 got %h want 00", d); end
    mem_read(16'h4015, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL unmapped_4015 got %h want 00", d); end
    mem_read(16'h8005, d);
    tests++; if (prg_addr !== 15'h0005) begin fails++; $display("FAIL prg_addr_8005 got %h want 0005", prg_addr); end
    tests++; if (d !== 8'h26) begin fails++; $display("FAIL prg_read_8005 got %h want 26", d); end
    mem_read(16'hFFFF, d);
    tests++; if (prg_addr !== 15'h7FFF) begin fails++; $display("FAIL prg_addr_ffff got %h want 7fff", prg_addr); end
    tests++; if (d !== 8'hFC) begin fails++; $display("FAIL prg_read_ffff got %h want fc", d); end
    $display("[TB] test_unmapped_prg done");
  endtask

  task automatic test_pad_serial();
    logic [7:0] d;
    logic       expv [10];
    expv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    pad_state = 16'h0091;
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    for (int k = 0; k < 10; k++) begin
      pad_read(16'h4016, d);
      tests++;
      if (d !== {7'b0, expv[k]}) begin
        fails++; $display("FAIL pad_serial_read%0d got %h want %h", k, d, {7'b0, expv[k]});
      end
    end
    // Strobe held high: reads follow the live A button and do not shift.
    cpu_write(16'h4016, 8'h01);
    pad_state = 16'h0080;
    pad_read(16'h4016, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL pad_live_a_high got %h want 01", d); end
    pad_state = 16'h0000;
    pad_read(16'h4016, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL pad_live_a_low got %h want 00", d); end
    cpu_write(16'h4016, 8'h00);
    $display("[TB] test_pad_serial done");
  endtask

  task automatic test_pad_two();
    logic [7:0] d;
    pad_state = 16'h8000;
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    pad_read(16'h4017, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL pad1_first got %h want 01", d); end
    pad_read(16'h4016, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL pad0_after_pad1 got %h want 00", d); end
    // pad0 = 40: a wrong shift on the $4017 read would expose a 1.
    pad_state = 16'h8040;
    cpu_write(16'h4016, 8'h01);
    cpu_write(16'h4016, 8'h00);
    pad_read(16'h4017, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL pad1_second got %h want 01", d); end
    pad_read(16'h4016, d);
    tests++; if (d !== 8'h00) begin fails++; $display("FAIL pad0_noshift got %h want 00", d); end
    pad_read(16'h4016, d);
    tests++; if (d !== 8'h01) begin fails++; $display("FAIL pad0_one_shift got %h want 01", d); end
    $display("[TB] test_pad_two done");
  endtask

`ifdef CPU_BUS_OAM_DMA_EN
  task automatic test_dma_ram();
    int n, pulses, first, order_err, rwe, bad, bad_k;
    for (int k = 0; k < 256; k++) cpu_write(16'(16'h0200 + k), 8'(k) ^ 8'hA5);
    cpu_write(16'h4014, 8'h02);
    run_dma(16'h4014, n, pulses, first, order_err, rwe);
    tests++; if (n !== 513) begin fails++; $display("FAIL dma_ram_stall_cycles got %0d want 513", n); end
    tests++; if (pulses !== 256) begin fails++; $display("FAIL dma_ram_pulses got %0d want 256", pulses); end
    tests++; if (first !== 2) begin fails++; $display("FAIL dma_ram_first_pulse got %0d want 2", first); end
    tests++; if (order_err !== 0) begin fails++; $display("FAIL dma_ram_oam_addr_order got %0d errors want 0", order_err); end
    tests++; if (rwe !== 0) begin fails++; $display("FAIL dma_ram_cpu_we_ignored got %0d ram_we want 0", rwe); end
    bad = 0; bad_k = -1;
    for (int k = 0; k < 256; k++) begin
      if (oam_mem[k] !== (8'(k) ^ 8'hA5)) begin bad++; if (bad_k < 0) bad_k = k; end
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL dma_ram_oam_data got %0d bad bytes (first %0d) want 0", bad, bad_k); end
    $display("[TB] test_dma_ram done: %0d stall cycles, %0d pulses", n, pulses);
  endtask

  task automatic test_dma_prg();
    int n, pulses, first, order_err, rwe, bad, bad_k;
    cpu_write(16'h4014, 8'h80);
    run_dma(16'h0005, n, pulses, first, order_err, rwe);
    tests++; if (n !== 513) begin fails++; $display("FAIL dma_prg_stall_cycles got %0d want 513", n); end
    tests++; if (rwe !== 0) begin fails++; $display("FAIL dma_prg_ram_we got %0d want 0", rwe); end
    bad = 0; bad_k = -1;
    for (int k = 0; k < 256; k++) begin
      if (oam_mem[k] !== 8'(k * 7 + 3)) begin bad++; if (bad_k < 0) bad_k = k; end
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL dma_prg_oam_data got %0d bad bytes (first %0d) want 0", bad, bad_k); end
    $display("[TB] test_dma_prg done: %0d pulses", pulses);
  endtask

  task automatic test_dma_reset();
    int n, pulses, first, order_err, rwe;
    cpu_write(16'h4014, 8'h02);
    n = 0;
    while (!(oam_we && oam_addr == 8'd100) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    tests++; if (n >= 1000) begin fails++; $display("FAIL dma_reset_reach_byte100 got timeout want byte 100"); end
    #2 reset = 1'b1;
    #1;
    tests++; if (cpu_stall !== 1'b0) begin fails++; $display("FAIL dma_reset_stall got %b want 0", cpu_stall); end
    tests++; if (oam_we !== 1'b0) begin fails++; $display("FAIL dma_reset_oam_we got %b want 0", oam_we); end
    pulses = 0;
    repeat (3) begin @(posedge clk); #1; if (oam_we || cpu_stall) pulses++; end
    reset = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (oam_we || cpu_stall) pulses++; end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL dma_reset_quiet got %0d active cycles want 0", pulses); end
    tests++; if (oam_addr !== 8'h00) begin fails++; $display("FAIL dma_reset_oam_addr got %h want 00", oam_addr); end
    cpu_write(16'h4014, 8'h02);
    run_dma(16'h4000, n, pulses, first, order_err, rwe);
    tests++; if (n !== 513) begin fails++; $display("FAIL dma_restart_stall got %0d want 513", n); end
    tests++; if (order_err !== 0 || pulses !== 256) begin fails++; $display("FAIL dma_restart_order got %0d errors %0d pulses want 0 and 256", order_err, pulses); end
    $display("[TB] test_dma_reset done");
  endtask
`else
  task automatic test_dma_disabled();
    int active;
    logic [7:0] d;
    cpu_write(16'h4014, 8'h02);
    active = 0;
    repeat (6) begin
      if (cpu_stall || oam_we) active++;
      @(posedge clk); #1;
    end
    tests++; if (active !== 0) begin fails++; $display("FAIL dma_off_activity got %0d cycles want 0", active); end
    tests++; if (oam_addr !== 8'h00) begin fails++; $display("FAIL dma_off_oam_addr got %h want 00", oam_addr); end
    tests++; if (oam_wdata !== 8'h00) begin fails++; $display("FAIL dma_off_oam_wdata got %h want 00", oam_wdata); end
    mem_read(16'h0000, d);
    tests++; if (d !== 8'h5A) begin fails++; $display("FAIL dma_off_ram_intact got %h want 5a", d); end
    $display("[TB] test_dma_disabled done");
  endtask
`endif

  initial begin
    test_reset();
    test_ram_mirror();
    test_ppu();
    test_unmapped_prg();
    test_pad_serial();
    test_pad_two();
`ifdef CPU_BUS_OAM_DMA_EN
    test_dma_ram();
    test_dma_prg();
    test_dma_reset();
`else
    test_dma_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_bus_decoder.md
# cpu_bus_decoder

Parametrised CPU-side address decoder that replaces the fixed-map mapper on the 6502 bus. It routes accesses to work RAM (with mirroring), PPU registers and PRG ROM. It owns a stalling OAM DMA engine and up to two serial controller ports with NES-accurate strobe and shift behaviour. It sits between the CPU core and the RAM, PPU and cartridge blocks.

## Interface
Parameters:
- NUM_PADS, 2: number of controller ports (1 or 2); port 0 at $4016, port 1 at $4017.
- RAM_AW, 11: work-RAM address width; RAM is mirrored across $0000-$1FFF.
- PRG_AW, 15: PRG ROM address width; PRG is mapped at $8000-$FFFF and mirrored if PRG_AW < 15.
- DMA_LEN, 256: bytes per OAM DMA transfer (power of two, at most 256).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- addr  in  16  CPU address.
- we  in  1  one-cycle write strobe per CPU write access.
- re  in  1  one-cycle read strobe per CPU read access.
- data_in  in  8  CPU write data.
- data_out  out  8  CPU read data (combinational).
- ram_addr  out  RAM_AW  work-RAM address.
- ram_we  out  1  work-RAM write enable.
- ram_rdata  in  8  work-RAM read data, 1-cycle synchronous latency.
- prg_addr  out  PRG_AW  PRG ROM address.
- prg_rdata  in  8  PRG read data, 1-cycle latency.
- ppu_cs  out  1  PPU register select, active-high.
- ppu_addr  out  3  PPU register index, addr[2:0].
- ppu_we  out  1  PPU register write.
- ppu_rdata  in  8  PPU register read data.
- cpu_stall  out  1  high while DMA owns the bus.
- oam_we  out  1  OAM write strobe.
- oam_addr  out  8  OAM byte address.
- oam_wdata  out  8  OAM write data.
- pad_state  in  8*NUM_PADS  live button levels per pad: bit7 A, bit6 B, bit5 Select, bit4 Start, bit3 Up, bit2 Down, bit1 Left, bit0 Right.

## Operation
- Decode, CPU side:
  - $0000-$1FFF goes to RAM: ram_we = we.
  - $2000-$3FFF goes to PPU: ppu_cs = 1, ppu_we = we.
  - $4016/$4017 go to the pads.
  - $8000-$FFFF goes to PRG.
  - All other addresses read 8'h00 and ignore writes.
- $4017 reads 8'h00 when NUM_PADS = 1.
- DMA FSM states are IDLE, ALIGN, READ, WRITE.
  - IDLE to ALIGN on `we` with addr = $4014. page <= data_in and idx <= 0.
  - ALIGN to READ after 1 cycle.
  - READ to WRITE: issue source address {page, idx} through the normal map (RAM or PRG; other pages yield 8'h00).
  - WRITE: oam_we = 1, oam_addr = idx, oam_wdata = source data. Then idx++. If idx = DMA_LEN-1, go to IDLE; otherwise go to READ.
- cpu_stall = 1 in every non-IDLE state. While stalled, CPU we/re are ignored, and the RAM/PRG address comes from the DMA.
- A $4014 write during DMA is impossible because the CPU is stalled; any such strobe is ignored.
- Pads: each port has an 8-bit shift register sr.
  - A write to $4016 sets strobe <= data_in[0]; this is shared by all pads.
  - While strobe = 1, every cycle loads sr <= pad_state slice.
  - A read returns {7'b0, sr[7]}.
  - On a `re` to a pad address with strobe = 0, that pad shifts sr <= {sr[6:0], 1'b1}. After 8 reads, the pad returns 1.
  - With strobe = 1, reads return the live A button and do not shift.
- Only the addressed pad shifts.

## Timing
- Reset values:
  - DMA state IDLE; cpu_stall 0; oam_we 0; oam_addr 0; oam_wdata 0.
  - strobe 0; all sr 8'hFF; ram_we, ppu_we 0.
- Decode outputs and data_out are combinational, same cycle. The RAM/PRG data path is the caller's 1-cycle latency.
- cpu_stall rises the cycle after the $4014 write strobe and stays high for exactly 1 + 2*DMA_LEN cycles (513 at default).
- oam_we pulses once per byte, on WRITE cycles only. The first pulse comes 3 cycles after the trigger strobe.
- A strobe write to $4016 affects the loaded sr from the next cycle.
- Simultaneous strobe=1 and read: load wins and no shift occurs.
- Reset asserted mid-DMA forces IDLE asynchronously; cpu_stall and oam_we drop immediately; partial OAM contents are left as written.
- idx wraps are not reachable; the FSM exits at DMA_LEN-1.

## Configuration
- CPU_BUS_OAM_DMA_EN defined: the DMA FSM is present as described.
- Undefined:
  - No DMA logic is built.
  - $4014 writes are ignored.
  - cpu_stall, oam_we, oam_addr and oam_wdata are tied 0.
  - RAM/PRG addressing is CPU-only.

## Test plan
- Reset, then read $0800 after writing 8'h5A to $0000 -> ram_addr 0 both times, data_out 8'h5A (mirror).
- Fill RAM $0200-$02FF with idx^8'hA5, write 8'h02 to $4014 -> cpu_stall high 513 cycles; 256 oam_we pulses; OAM[k] = k^8'hA5.
- Write 8'h80 to $4014 -> OAM loaded from prg_addr {8'h80, idx} window, masked to PRG_AW.
- pad_state[7:0] = 8'b1001_0001; write 1 then 0 to $4016; 10 reads of $4016 -> 1,0,0,1,0,0,0,1,1,1.
- NUM_PADS=2: pad1 = 8'h80, pad0 = 8'h00; strobe; read $4017 once, then $4016 -> 1 then 0; pad0 does not shift on the $4017 read.
- Assert reset at DMA byte 100 -> cpu_stall 0 same cycle; no further oam_we; a new $4014 write restarts at oam_addr 0.
